morse_tx_arbiter: RTL and testbench

Controller that shares one Morse symbol shifter between two letter requesters. It arbitrates round-robin between requester A and requester B and captures the granted 3-bit letter code. It then serialises the 12-bit Morse pattern MSB-first at one symbol per tick and appends an inter-letter gap of low symbols. It sits between user-side letter sources (switch/key logic or a message sequencer) and the LED/driver output.

---
 rtl/morse_pkg.sv | 31 +++
 rtl/morse_tick_div.sv | 38 +++
 rtl/morse_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_morse_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter-code table, transmitter state encoding and
// symbol-count constant used by the Morse transmit blocks.
package morse_pkg;

    localparam int unsigned SYMBOL_LEN = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } tx_state_e;

    // Each pattern is sent MSB-first; trailing zeros pad the letter to SYMBOL_LEN.
    function automatic logic [SYMBOL_LEN-1:0] letter_pattern(input logic [2:0] code);
        logic [SYMBOL_LEN-1:0] pat;
        pat = '0;
        case (code)
            3'b000: pat = 12'b1011_1000_0000;
            3'b001: pat = 12'b1110_1010_1000;
            3'b010: pat = 12'b1110_1011_1010;
            3'b011: pat = 12'b1110_1010_0000;
            3'b100: pat = 12'b1000_0000_0000;
            3'b101: pat = 12'b1010_1110_1000;
            3'b110: pat = 12'b1110_1110_1000;
            3'b111: pat = 12'b1010_1010_0000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/morse_tick_div.sv
// Loadable down-counter producing one Tick every DIV enabled cycles; reloads
// itself on each Tick so symbols stay exactly DIV cycles long.
module morse_tick_div #(
    parameter int unsigned DIV = 260
) (
    input  logic ClockIn,
    input  logic Resetn,
    input  logic Load,
    input  logic Enable,
    output logic Tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Load) begin
            cnt_d = RELOAD;
        end else if (Enable) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = Enable && (cnt_q == '0);

endmodule

// File: rtl/morse_tx_arbiter.sv
// Round-robin arbiter between two letter requesters feeding one Morse symbol
// shifter; serialises the granted letter then an inter-letter gap.
module morse_tx_arbiter
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 260,
    parameter int unsigned GAP_BITS = 3
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       ReqA,
    input  logic [2:0] LetterA,
    input  logic       ReqB,
    input  logic [2:0] LetterB,
    output logic       GrantA,
    output logic       GrantB,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       DoneA,
    output logic       DoneB
);

    localparam int unsigned GAP_W   = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam int unsigned GAP_END = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_END);
    localparam logic [3:0]       BIT_LAST = 4'(SYMBOL_LEN - 1);

    tx_state_e             state_q, state_d;
    logic                  last_b_q, last_b_d;
    logic                  owner_b_q, owner_b_d;
    logic [2:0]            code_q, code_d;
    logic [SYMBOL_LEN-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  grant_a_q, grant_a_d;
    logic                  grant_b_q, grant_b_d;
    logic                  done_a_q, done_a_d;
    logic                  done_b_q, done_b_d;

    logic tick;
    logic div_load;
    logic div_en;
    logic win_b;
    logic letter_done;

    assign div_load = (state_q == ST_LOAD);
    assign div_en   = (state_q == ST_SEND) || (state_q == ST_GAP);

    morse_tick_div #(
        .DIV(TICK_DIV)
    ) u_tick_div (
        .ClockIn(ClockIn),
        .Resetn (Resetn),
        .Load   (div_load),
        .Enable (div_en),
        .Tick   (tick)
    );

    // On a tie the requester not served last wins.
    assign win_b = ReqB && (!ReqA || !last_b_q);

    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            owner_b_q <= 1'b0;
            code_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            owner_b_q <= owner_b_d;
            code_q    <= code_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ReqA || ReqB) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (tick && (bit_cnt_q == BIT_LAST)) begin
                    state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: if (tick && (gap_cnt_q == GAP_LAST)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign letter_done = (state_d == ST_IDLE) &&
                         ((state_q == ST_SEND) || (state_q == ST_GAP));

    always_comb begin
        last_b_d  = last_b_q;
        owner_b_d = owner_b_q;
        code_d    = code_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ReqA || ReqB) begin
                    grant_a_d = !win_b;
                    grant_b_d = win_b;
                    owner_b_d = win_b;
                    code_d    = win_b ? LetterB : LetterA;
                end
            end
            ST_LOAD: begin
                shift_d   = letter_pattern(code_q);
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
            ST_SEND: begin
                if (tick) begin
                    shift_d   = {shift_q[SYMBOL_LEN-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (tick) gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: ;
        endcase
        if (letter_done) begin
            done_a_d = !owner_b_q;
            done_b_d = owner_b_q;
            last_b_d = owner_b_q;
        end
    end

    always_comb begin
        GrantA     = grant_a_q;
        GrantB     = grant_b_q;
        DoneA      = done_a_q;
        DoneB      = done_b_q;
        Busy       = (state_q != ST_IDLE);
        DotDashOut = (state_q == ST_SEND) && shift_q[SYMBOL_LEN-1];
        NewBitOut  = tick && div_en;
    end

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Scoreboard bench for morse_tx_arbiter: stimulus queues expected grants,
// symbols and completions; a negedge monitor pops and compares them.
module tb_morse_tx_arbiter;

    localparam int TD   = 4;
    localparam int GB   = 3;
    localparam int LAT  = 12 * TD + GB * TD + 1;
    localparam int LAT0 = 12 * TD + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [2:0] let_a = '0, let_b = '0;
    logic       ga, gb, dd, nb, busy, da, db;

    logic       z_req_a = 1'b0, z_req_b = 1'b0;
    logic [2:0] z_let_a = '0, z_let_b = '0;
    logic       z_ga, z_gb, z_dd, z_nb, z_busy, z_da, z_db;

    logic [11:0] lut [8];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -100;
    int grant_cyc = 0;
    int nb_cnt = 0;
    int hi_cnt = 0;

    bit exp_sym[$];
    bit exp_grant[$];
    bit exp_done[$];
    int exp_hi[$];

    morse_tx_arbiter #(.TICK_DIV(TD), .GAP_BITS(GB)) dut (
        .ClockIn(clk), .Resetn(rst_n),
        .ReqA(req_a), .LetterA(let_a), .ReqB(req_b), .LetterB(let_b),
        .GrantA(ga), .GrantB(gb), .DotDashOut(dd), .NewBitOut(nb),
        .Busy(busy), .DoneA(da), .DoneB(db)
    );

    morse_tx_arbiter #(.TICK_DIV(TD), .GAP_BITS(0)) dut_nogap (
        .ClockIn(clk), .Resetn(rst_n),
        .ReqA(z_req_a), .LetterA(z_let_a), .ReqB(z_req_b), .LetterB(z_let_b),
        .GrantA(z_ga), .GrantB(z_gb), .DotDashOut(z_dd), .NewBitOut(z_nb),
        .Busy(z_busy), .DoneA(z_da), .DoneB(z_db)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_letter(input bit owner, input logic [2:0] code,
                               input int nsym, input bit with_done);
        logic [11:0] p;
        p = lut[code];
        for (int i = 0; i < nsym; i++) exp_sym.push_back(p[11 - i]);
        exp_grant.push_back(owner);
        if (with_done) begin
            for (int i = 0; i < GB; i++) exp_sym.push_back(1'b0);
            exp_done.push_back(owner);
            exp_hi.push_back($countones(p) * TD);
        end
    endtask

    task automatic wait_grant(input bit nogap, output bit owner, output int at);
        owner = 1'b0;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (nogap ? (z_ga || z_gb) : (ga || gb)) begin
                owner = nogap ? z_gb : gb;
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL grant_wait: no grant within 400 cycles, expected one");
    endtask

    task automatic wait_done(input bit nogap, output bit owner, output int at);
        owner = 1'b0;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (nogap ? (z_da || z_db) : (da || db)) begin
                owner = nogap ? z_db : db;
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL done_wait: no done within 400 cycles, expected one");
    endtask

    // Monitor: every output event of the main instance is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (nb) begin
                nb_cnt++;
                check("symbol_expected", int'(exp_sym.size() > 0), 1);
                if (exp_sym.size() > 0) check("symbol", int'(dd), int'(exp_sym.pop_front()));
            end
            if (dd) hi_cnt++;
            check("grant_done_apart", int'((ga || gb) && (da || db)), 0);
            if (ga || gb) begin
                check("grant_onehot", int'(ga && gb), 0);
                check("grant_expected", int'(exp_grant.size() > 0), 1);
                if (exp_grant.size() > 0) check("grant_owner", int'(gb), int'(exp_grant.pop_front()));
                grant_cyc = cyc;
                nb_cnt = 0;
                hi_cnt = 0;
            end
            if (da || db) begin
                check("done_onehot", int'(da && db), 0);
                check("done_expected", int'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) check("done_owner", int'(db), int'(exp_done.pop_front()));
                check("done_latency", cyc - grant_cyc, LAT);
                check("done_newbits", nb_cnt, 12 + GB);
                if (exp_hi.size() > 0) check("mark_cycles", hi_cnt, exp_hi.pop_front());
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit   o;
        int   g, d, req_cyc, nbits;
        logic [11:0] zp;

        lut[0] = 12'b1011_1000_0000;
        lut[1] = 12'b1110_1010_1000;
        lut[2] = 12'b1110_1011_1010;
        lut[3] = 12'b1110_1010_0000;
        lut[4] = 12'b1000_0000_0000;
        lut[5] = 12'b1010_1110_1000;
        lut[6] = 12'b1110_1110_1000;
        lut[7] = 12'b1010_1010_0000;

        // Reset then idle.
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", int'({ga, gb, dd, nb, busy, da, db}), 0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_outputs", int'({ga, gb, dd, nb, busy, da, db}), 0);
        end

        // Single letter from A.
        push_letter(1'b0, 3'b100, 12, 1'b1);
        @(posedge clk); #1 req_a = 1'b1; let_a = 3'b100;
        wait_grant(1'b0, o, g);
        @(posedge clk); #1 req_a = 1'b0;
        @(negedge clk);
        check("first_symbol", int'({busy, dd}), 3);
        wait_done(1'b0, o, d);

        // Tie from reset: A, B, A, B each one cycle after the previous Done.
        @(posedge clk); #1;
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; let_a = 3'b000; let_b = 3'b111;
        push_letter(1'b0, 3'b000, 12, 1'b1);
        push_letter(1'b1, 3'b111, 12, 1'b1);
        push_letter(1'b0, 3'b000, 12, 1'b1);
        push_letter(1'b1, 3'b111, 12, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_grant(1'b0, o, g);
        for (int k = 1; k < 4; k++) begin
            wait_grant(1'b0, o, g);
            check("tie_back_to_back", g - last_done_cyc, 1);
            if (k == 2) begin @(posedge clk); #1 req_a = 1'b0; end
        end
        @(posedge clk); #1 req_b = 1'b0;
        wait_done(1'b0, o, d);

        // Request from B while A is sending.
        push_letter(1'b0, 3'b011, 12, 1'b1);
        push_letter(1'b1, 3'b101, 12, 1'b1);
        @(posedge clk); #1 req_a = 1'b1; let_a = 3'b011;
        wait_grant(1'b0, o, g);
        @(posedge clk); #1 req_a = 1'b0;
        repeat (10) @(posedge clk);
        #1 req_b = 1'b1; let_b = 3'b101;
        wait_grant(1'b0, o, g);
        check("busy_req_grant_after_done", g - last_done_cyc, 1);
        @(posedge clk); #1 req_b = 1'b0;
        wait_done(1'b0, o, d);

        // Reset during the 5th symbol of code 010.
        push_letter(1'b0, 3'b010, 4, 1'b0);
        @(posedge clk); #1 req_a = 1'b1; let_a = 3'b010;
        wait_grant(1'b0, o, g);
        @(posedge clk); #1 req_a = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", int'({ga, gb, dd, nb, busy, da, db}), 0);
        rst_n = 1'b1;
        push_letter(1'b1, 3'b010, 12, 1'b1);
        req_b = 1'b1; let_b = 3'b010;
        req_cyc = cyc;
        wait_grant(1'b0, o, g);
        check("midreset_b_grant_delay", g - req_cyc, 1);
        @(posedge clk); #1 req_b = 1'b0;
        wait_done(1'b0, o, d);

        // No-gap instance: code 110 from A then B back to back.
        zp = lut[6];
        @(posedge clk); #1;
        z_let_a = 3'b110; z_let_b = 3'b110; z_req_a = 1'b1; z_req_b = 1'b1;
        wait_grant(1'b1, o, g);
        check("nogap_first_owner", int'(o), 0);
        @(posedge clk); #1 z_req_a = 1'b0;
        nbits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (z_nb) begin
                if (nbits < 12) check("nogap_symbol", int'(z_dd), int'(zp[11 - nbits]));
                nbits++;
            end
            if (z_da || z_db) break;
        end
        check("nogap_done_owner", int'({z_da, z_db}), 2);
        check("nogap_done_latency", cyc - g, LAT0);
        check("nogap_newbits", nbits, 12);
        d = cyc;
        wait_grant(1'b1, o, g);
        check("nogap_second_owner", int'(o), 1);
        check("nogap_back_to_back", g - d, 1);
        @(posedge clk); #1 z_req_b = 1'b0;
        wait_done(1'b1, o, d);
        check("nogap_second_done_owner", int'(o), 1);

        repeat (4) @(negedge clk);
        check("leftover_symbols", exp_sym.size(), 0);
        check("leftover_grants", exp_grant.size(), 0);
        check("leftover_dones", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
